// File: rtl/bsk_ntw_srv_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// bsk_ntw_srv_cmd_sequencer
//
// Server-side receiver of the BSK-network batch-command broadcast. Each
// command pulse from the arbiter is stored in a local circular FIFO whose
// depth mirrors the arbiter's credit view. The head command is replayed for
// BSK_DIST_ITER_NB key-slice broadcast iterations over a valid/ready
// interface. Every accepted iteration returns one srv_bdc_avail pulse to the
// arbiter, and the head entry is freed on its last iteration, which keeps
// this server in lock-step with the arbiter's read pointer.
//
// Ports:
//   clk                     clock
//   s_rst_n                 synchronous reset, active-low
//   arb_srv_batch_cmd       command broadcast by the arbiter
//   arb_srv_batch_cmd_avail one-cycle write strobe (no backpressure)
//   srv_bdc_cmd             head command under broadcast
//   srv_bdc_iter            current iteration index
//   srv_bdc_last            iteration index is BSK_DIST_ITER_NB-1
//   srv_bdc_vld             iteration request valid
//   srv_bdc_rdy             broadcast engine accepts the iteration
//   srv_bdc_avail           vld & rdy, returned to the arbiter
//   fifo_cnt                stored commands, including the one in progress
//   overflow_err            sticky: a write arrived while full with no pop
//
// OVF_FATAL_EN stops simulation on an overflow; clear it only when an
// overflow is deliberately provoked.
// ---------------------------------------------------------------------------
module bsk_ntw_srv_cmd_sequencer #(
  parameter int BR_BATCH_CMD_W     = 32,
  parameter int SRV_CMD_FIFO_DEPTH = 4,
  parameter int BSK_DIST_ITER_NB   = 8,
  parameter int BSK_DIST_ITER_W    = (BSK_DIST_ITER_NB > 1) ? $clog2(BSK_DIST_ITER_NB) : 1,
  parameter int CNT_W              = $clog2(SRV_CMD_FIFO_DEPTH + 1),
  parameter bit OVF_FATAL_EN       = 1'b1
) (
  input  logic                       clk,
  input  logic                       s_rst_n,
  input  logic [BR_BATCH_CMD_W-1:0]  arb_srv_batch_cmd,
  input  logic                       arb_srv_batch_cmd_avail,
  output logic [BR_BATCH_CMD_W-1:0]  srv_bdc_cmd,
  output logic [BSK_DIST_ITER_W-1:0] srv_bdc_iter,
  output logic                       srv_bdc_last,
  output logic                       srv_bdc_vld,
  input  logic                       srv_bdc_rdy,
  output logic                       srv_bdc_avail,
  output logic [CNT_W-1:0]           fifo_cnt,
  output logic                       overflow_err
);

  localparam int PTR_W = (SRV_CMD_FIFO_DEPTH > 1) ? $clog2(SRV_CMD_FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0]           PTR_MAX  = PTR_W'(SRV_CMD_FIFO_DEPTH - 1);
  localparam logic [BSK_DIST_ITER_W-1:0] ITER_MAX = BSK_DIST_ITER_W'(BSK_DIST_ITER_NB - 1);
  localparam logic [CNT_W-1:0]           CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                      state, state_nxt;
  logic [BR_BATCH_CMD_W-1:0]   mem [SRV_CMD_FIFO_DEPTH];
  logic [PTR_W-1:0]            wp, rp;
  logic                        wp_msb, rp_msb;
  logic                        full, empty;
  logic                        hs, pop, wr_acc, ovf_set;
  logic [BSK_DIST_ITER_W-1:0]  iter, iter_nxt;

  assign empty = (wp == rp) && (wp_msb == rp_msb);
  assign full  = (wp == rp) && (wp_msb != rp_msb);

  // A command written last cycle is presented while still in IDLE, giving a
  // one-cycle write-to-valid latency; RUN always holds a non-empty FIFO.
  assign srv_bdc_vld   = (state == RUN) || !empty;
  assign srv_bdc_cmd   = mem[rp];
  assign srv_bdc_iter  = iter;
  assign srv_bdc_last  = (iter == ITER_MAX);
  assign hs            = srv_bdc_vld && srv_bdc_rdy;
  assign srv_bdc_avail = hs;
  assign pop           = hs && srv_bdc_last;
  // A pop in the same cycle frees the slot at wp (== rp when full), so the
  // write may land there.
  assign wr_acc        = arb_srv_batch_cmd_avail && (!full || pop);
  assign ovf_set       = arb_srv_batch_cmd_avail && full && !pop;

  always_comb begin
    state_nxt = state;
    iter_nxt  = iter;
    case (state)
      IDLE:    if (!empty) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (hs) begin
      if (srv_bdc_last) begin
        iter_nxt  = '0;
        // Stay in RUN when another command remains after this pop so that
        // consecutive commands stream with no bubble.
        state_nxt = (fifo_cnt == CNT_ONE && !wr_acc) ? IDLE : RUN;
      end else begin
        iter_nxt  = iter + BSK_DIST_ITER_W'(1);
        state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      state        <= IDLE;
      iter         <= '0;
      wp           <= '0;
      rp           <= '0;
      wp_msb       <= 1'b0;
      rp_msb       <= 1'b0;
      fifo_cnt     <= '0;
      overflow_err <= 1'b0;
    end else begin
      state <= state_nxt;
      iter  <= iter_nxt;
      if (wr_acc) begin
        if (wp == PTR_MAX) begin
          wp     <= '0;
          wp_msb <= !wp_msb;
        end else begin
          wp <= wp + PTR_W'(1);
        end
      end
      if (pop) begin
        if (rp == PTR_MAX) begin
          rp     <= '0;
          rp_msb <= !rp_msb;
        end else begin
          rp <= rp + PTR_W'(1);
        end
      end
      case ({wr_acc, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
        2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (ovf_set) overflow_err <= 1'b1;
    end
  end

  // Command storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp] <= arb_srv_batch_cmd;
  end

  always @(posedge clk) begin
    if (OVF_FATAL_EN && s_rst_n) begin
      assert (!ovf_set)
        else $fatal(1, "bsk_ntw_srv_cmd_sequencer: command write while FIFO full");
    end
  end

endmodule

// File: doc/bsk_ntw_srv_cmd_sequencer.md
Name: bsk_ntw_srv_cmd_sequencer

Overview:
Server-side receiver of the broadcast batch-command stream in the BSK network. It captures each command pulse into a local command FIFO, sized to match the arbiter's credit view. For the head command it sequences BSK_DIST_ITER_NB key-slice broadcast iterations through a valid/ready interface. Every accepted iteration emits one srv_bdc_avail pulse back to the arbiter, and the FIFO entry is freed on the last iteration. This keeps every server in lock-step with the arbiter's read pointer.

Parameters:
BR_BATCH_CMD_W, 32, width of one packed batch command.
SRV_CMD_FIFO_DEPTH, 4, command FIFO entries; any value >=1, need not be a power of 2; must equal the arbiter's setting.
BSK_DIST_ITER_NB, 8, broadcast iterations per command, >=1.
BSK_DIST_ITER_W, $clog2(BSK_DIST_ITER_NB) (min 1), iteration index width.
CNT_W, $clog2(SRV_CMD_FIFO_DEPTH+1), occupancy width.

Ports:
clk  in  1  clock.
s_rst_n  in  1  synchronous reset, active-low.
arb_srv_batch_cmd  in  BR_BATCH_CMD_W  broadcast command from the arbiter.
arb_srv_batch_cmd_avail  in  1  one-cycle write pulse; there is no backpressure.
srv_bdc_cmd  out  BR_BATCH_CMD_W  head command being broadcast.
srv_bdc_iter  out  BSK_DIST_ITER_W  current iteration index.
srv_bdc_last  out  1  high when srv_bdc_iter == BSK_DIST_ITER_NB-1.
srv_bdc_vld  out  1  iteration request valid.
srv_bdc_rdy  in  1  downstream broadcast engine accepts the iteration.
srv_bdc_avail  out  1  pulse = srv_bdc_vld & srv_bdc_rdy; returned to the arbiter.
fifo_cnt  out  CNT_W  stored commands, including the one in progress.
overflow_err  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, s_rst_n=0):
  - pointers, fifo_cnt, srv_bdc_iter and FSM are cleared; FSM returns to IDLE.
  - srv_bdc_vld=0, srv_bdc_avail=0, srv_bdc_last=0 (or 1 if BSK_DIST_ITER_NB==1), overflow_err=0.
  - srv_bdc_cmd is don't-care.
  - Reset mid-sequence drops all stored commands; no further srv_bdc_avail pulse follows.
- FIFO storage:
  - circular buffer with wp/rp, each wrapping at SRV_CMD_FIFO_DEPTH-1 to 0, plus an msb toggle on wrap.
  - full = lsb equal and msb differ; empty = both equal.
  - Data storage has no reset.
- Write: on arb_srv_batch_cmd_avail, store at wp and advance wp.
  - Write while full with no same-cycle pop: the write is dropped, overflow_err is set (sticky until reset), and the simulation asserts $fatal.
  - Write while full with a same-cycle pop is legal and accepted.
- FSM, IDLE:
  - if the FIFO is non-empty, go to RUN with iter=0.
  - A command written in cycle T gives srv_bdc_vld=1 in T+1 (registered write, 1-cycle latency).
- FSM, RUN:
  - srv_bdc_vld=1; srv_bdc_cmd = mem[rp] and is stable while vld & ~rdy.
  - On handshake with iter < NB-1: iter+1.
  - On handshake with iter == NB-1: pop (rp advance), iter=0; stay in RUN if another command remains after the pop, otherwise go to IDLE.
  - Back-to-back commands therefore stream with no bubble cycle.
- srv_bdc_vld may not drop without a handshake (AXI-style).
- fifo_cnt: +1 on accepted write, -1 on pop, unchanged when both occur together; range 0..SRV_CMD_FIFO_DEPTH.
- srv_bdc_avail count per command is exactly BSK_DIST_ITER_NB. This matches the arbiter's counter, whose read pointer then advances one cycle after our pop, so the arbiter never writes into a slot we have not freed.
- BSK_DIST_ITER_NB==1: every handshake pops.
- Commands are broadcast in arrival order. No deduplication is done here; the arbiter already guarantees unique br_loop values.

Test Plan:
- Single command: DEPTH=4, NB=8, rdy=1, write cmd 0x5 at T -> vld from T+1 to T+8, iter 0..7, last at T+8, 8 avail pulses, fifo_cnt 1 at T+1..T+8 and 0 at T+9, IDLE at T+9.
- Back-to-back: 3 commands 0xA, 0xB, 0xC written on consecutive cycles, rdy=1 -> 24 contiguous avail pulses, with cmd changing 0xA->0xB->0xC exactly after each iter=7 handshake and no bubble.
- Backpressure: rdy toggles 1,0,0,1,... -> cmd and iter hold during rdy=0, avail only on handshake, total pulses per command = 8.
- Full plus simultaneous pop: fill 4 commands, then write a 5th in the same cycle as the last-iteration handshake of the head -> write accepted, fifo_cnt stays 4, overflow_err=0.
- Overflow: fill 4 commands with rdy=0, write a 5th -> overflow_err=1 (sticky), fifo_cnt=4, and the 5th command is never broadcast.
- Wrap and reset: DEPTH=3 non-power-of-2, stream 7 commands -> correct order across the wrap. Then assert reset mid-iteration 3 -> vld=0 and fifo_cnt=0 the next cycle, no extra avail pulse, and a new command after reset starts at iter=0.
